// File: rtl/ball_engine.sv
// ball_engine: fixed-point PONG ball motion, wall/paddle bounce, scoring and serve/game-over FSM; BALL_SPIN_EN adds paddle spin.
// Latency: one step per tick, all outputs registered; no backpressure, tick/start are single-cycle strobes.
module ball_engine #(
  parameter int HOR_PIX   = 1024,
  parameter int VER_PIX   = 768,
  parameter int BALL_SIZE = 10,
  parameter int PAD_X_L   = 30,
  parameter int PAD_X_R   = 994,
  parameter int PAD_W     = 15,
  parameter int PAD_H     = 100,
  parameter int FRAC      = 4,
  parameter int V_INIT    = 16,
  parameter int V_STEP    = 2,
  parameter int V_MAX     = 128,
  parameter int WIN_SCORE = 9,
  parameter int SCORE_W   = 7,
  parameter int SERVE_DLY = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [10:0]        pad1_y,
  input  logic [10:0]        pad2_y,
  input  logic [3:0]         rnd,
  output logic [10:0]        xpos,
  output logic [10:0]        ypos,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               hit,
  output logic               point,
  output logic               game_over
);

  localparam int PW = 11 + FRAC;
  localparam int VW = 8 + FRAC;
  localparam int NW = PW + 1;
  localparam int DW = $clog2(SERVE_DLY + 1);

  localparam logic [PW-1:0] X_C   = PW'(((HOR_PIX - BALL_SIZE) / 2) << FRAC);
  localparam logic [PW-1:0] Y_C   = PW'(((VER_PIX - BALL_SIZE) / 2) << FRAC);
  localparam logic [PW-1:0] LF_X  = PW'((PAD_X_L + PAD_W) << FRAC);
  localparam logic [PW-1:0] RF_X  = PW'((PAD_X_R - PAD_W - BALL_SIZE) << FRAC);
  localparam logic [PW-1:0] XM_X  = PW'((HOR_PIX - BALL_SIZE) << FRAC);
  localparam logic [PW-1:0] YM_Y  = PW'((VER_PIX - BALL_SIZE) << FRAC);
  localparam logic signed [NW-1:0] LF   = NW'((PAD_X_L + PAD_W) << FRAC);
  localparam logic signed [NW-1:0] RF   = NW'((PAD_X_R - PAD_W - BALL_SIZE) << FRAC);
  localparam logic signed [NW-1:0] XMAX = NW'((HOR_PIX - BALL_SIZE) << FRAC);
  localparam logic signed [NW-1:0] YMAX = NW'((VER_PIX - BALL_SIZE) << FRAC);
  localparam logic signed [VW-1:0] V_INIT_S = VW'(V_INIT);
  localparam logic signed [VW-1:0] V_STEP_S = VW'(V_STEP);
  localparam logic signed [VW-1:0] V_MAX_S  = VW'(V_MAX);
  localparam logic [SCORE_W-1:0]   WIN      = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAME_OVER} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          x_q, x_d, y_q, y_d;
  logic signed [VW-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [SCORE_W-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic                   dir_q, dir_d;  // 1 = serve toward the right
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   hit_q, hit_d, point_q, point_d, over_q, over_d;

  logic signed [NW-1:0]   x_s, y_s, nx, ny;
  logic signed [VW-1:0]   avx, avy, inc, vx_hit, mag;
  logic [10:0]            yi;
  logic                   l_ovl, r_ovl, hit_l, hit_r, miss_l, miss_r;

`ifdef BALL_SPIN_EN
  localparam logic signed [13:0] SPIN_OFS = 14'(BALL_SIZE / 2 - PAD_H / 2);
  localparam logic signed [13:0] SP_MAX   = 14'(V_MAX);
  logic [10:0]            py;
  logic signed [13:0]     spin_raw;
  logic signed [VW-1:0]   spin_v;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    point_d = 1'b0;

    x_s    = {1'b0, x_q};
    y_s    = {1'b0, y_q};
    nx     = x_s + {{(NW-VW){vx_q[VW-1]}}, vx_q};
    ny     = y_s + {{(NW-VW){vy_q[VW-1]}}, vy_q};
    avx    = vx_q[VW-1] ? -vx_q : vx_q;
    avy    = vy_q[VW-1] ? -vy_q : vy_q;
    inc    = avx + V_STEP_S;
    vx_hit = (inc > V_MAX_S) ? V_MAX_S : inc;
    mag    = VW'({rnd[2:0], 1'b0});
    yi     = y_q[PW-1:FRAC];

    l_ovl  = ({1'b0, yi} < {1'b0, pad1_y} + 12'(PAD_H)) && ({1'b0, yi} + 12'(BALL_SIZE) > {1'b0, pad1_y});
    r_ovl  = ({1'b0, yi} < {1'b0, pad2_y} + 12'(PAD_H)) && ({1'b0, yi} + 12'(BALL_SIZE) > {1'b0, pad2_y});
    hit_l  = vx_q[VW-1] && (x_s >= LF) && (nx < LF) && l_ovl;
    hit_r  = !vx_q[VW-1] && (vx_q != '0) && (x_s <= RF) && (nx > RF) && r_ovl;
    miss_l = nx[NW-1] || (nx == '0);
    miss_r = nx >= XMAX;

`ifdef BALL_SPIN_EN
    py       = hit_l ? pad1_y : pad2_y;
    spin_raw = ($signed({3'b0, yi}) - $signed({3'b0, py}) + SPIN_OFS) <<< 1;
    if (spin_raw > SP_MAX)       spin_v = V_MAX_S;
    else if (spin_raw < -SP_MAX) spin_v = -V_MAX_S;
    else                         spin_v = VW'(spin_raw);
`endif

    case (state_q)
      SERVE: begin
        x_d  = X_C;
        y_d  = Y_C;
        vx_d = '0;
        vy_d = '0;
        if (start) begin
          vx_d    = dir_q ? V_INIT_S : -V_INIT_S;
          vy_d    = rnd[3] ? -mag : mag;
          state_d = PLAY;
        end
      end
      PLAY: if (tick) begin
        // Horizontal first so a wall bounce on the same tick overrides paddle spin.
        if (hit_l || hit_r) begin
          x_d   = hit_l ? LF_X : RF_X;
          vx_d  = hit_l ? vx_hit : -vx_hit;
          hit_d = 1'b1;
`ifdef BALL_SPIN_EN
          vy_d  = spin_v;
`endif
        end else if (miss_l || miss_r) begin
          x_d     = miss_l ? '0 : XM_X;
          dir_d   = miss_r;
          point_d = 1'b1;
          cnt_d   = '0;
          state_d = SCORED;
          if (miss_l && s2_q != WIN) s2_d = s2_q + SCORE_W'(1);
          if (miss_r && s1_q != WIN) s1_d = s1_q + SCORE_W'(1);
        end else begin
          x_d = nx[PW-1:0];
        end
        if (ny[NW-1] || ny == '0) begin
          y_d  = '0;
          vy_d = avy;
        end else if (ny >= YMAX) begin
          y_d  = YM_Y;
          vy_d = -avy;
        end else begin
          y_d  = ny[PW-1:0];
        end
      end
      SCORED: begin
        x_d  = X_C;
        y_d  = Y_C;
        vx_d = '0;
        vy_d = '0;
        if (tick) begin
          if (cnt_q == DW'(SERVE_DLY - 1)) begin
            cnt_d   = '0;
            state_d = (s1_q == WIN || s2_q == WIN) ? GAME_OVER : SERVE;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end
      default: begin
        x_d  = X_C;
        y_d  = Y_C;
        vx_d = '0;
        vy_d = '0;
        if (start) begin
          s1_d    = '0;
          s2_d    = '0;
          state_d = SERVE;
        end
      end
    endcase

    over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SERVE;
      x_q     <= X_C;
      y_q     <= Y_C;
      vx_q    <= '0;
      vy_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      point_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      point_q <= point_d;
      over_q  <= over_d;
    end
  end

  assign xpos      = x_q[PW-1:FRAC];
  assign ypos      = y_q[PW-1:FRAC];
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign hit       = hit_q;
  assign point     = point_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: serve, motion, paddle hit, wall bounce, misses, serve delay, game over.
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [10:0] pad1_y = 11'd0;
  logic [10:0] pad2_y = 11'd0;
  logic [3:0]  rnd = 4'd0;
  logic [10:0] xpos, ypos;
  logic [6:0]  score1, score2;
  logic        hit, point, game_over;

  int n_asserts = 0;
  int n_fail = 0;
  bit seen;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .pad1_y(pad1_y), .pad2_y(pad2_y), .rnd(rnd),
    .xpos(xpos), .ypos(ypos), .score1(score1), .score2(score2),
    .hit(hit), .point(point), .game_over(game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick_until_point(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      do_tick();
      if (point) got = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_xpos", xpos, 507);
    check("rst_ypos", ypos, 379);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_pulses", {hit, point, game_over}, 0);
    rst = 1'b0;

    // Serve left, flat, into paddle at y=330
    pad1_y = 11'd330;
    pad2_y = 11'd330;
    rnd    = 4'b0000;
    pulse_start();
    ticks(10);
    check("serve_xpos", xpos, 497);
    check("serve_ypos", ypos, 379);
    ticks(452);
    check("prehit_xpos", xpos, 45);
    check("prehit_hit", hit, 0);
    do_tick();
    check("hit_xpos", xpos, 45);
    check("hit_pulse", hit, 1);
    @(negedge clk);
    check("hit_pulse_end", hit, 0);
    ticks(8);
    check("post_hit_xpos", xpos, 54);
`ifdef BALL_SPIN_EN
    check("post_hit_ypos", ypos, 383);
`else
    check("post_hit_ypos", ypos, 379);
`endif

    // Asynchronous reset in the middle of play
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_xpos", xpos, 507);
    check("async_rst_ypos", ypos, 379);
    check("async_rst_pulses", {hit, point, game_over}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Left miss past a paddle parked at the top
    pad1_y = 11'd0;
    pulse_start();
    ticks(506);
    check("pre_miss_xpos", xpos, 1);
    check("pre_miss_point", point, 0);
    do_tick();
    check("miss_xpos", xpos, 0);
    check("miss_point", point, 1);
    check("miss_score2", score2, 1);
    check("miss_score1", score1, 0);
    @(negedge clk);
    check("point_end", point, 0);
    check("scored_centre", xpos, 507);
    ticks(59);
    pulse_start();
    do_tick();
    check("scored_ignores_start", xpos, 507);
    pulse_start();
    do_tick();
    check("reserve_xpos", xpos, 506);

    // Top wall bounce with rnd=1111 (vy=-14)
    hard_reset();
    rnd = 4'b1111;
    pulse_start();
    ticks(433);
    check("pre_top_ypos", ypos, 0);
    do_tick();
    check("top_clamp_ypos", ypos, 0);
    check("top_xpos", xpos, 73);
    ticks(2);
    check("top_bounce_ypos", ypos, 1);

    // Run score1 to WIN_SCORE; paddle offset gives ball_cy = pad_cy + 20
    hard_reset();
    rnd    = 4'b0000;
    pad1_y = 11'd314;
    pad2_y = 11'd2000;
    pulse_start();
    ticks(463);
    check("spin_hit_pulse", hit, 1);
    check("spin_hit_xpos", xpos, 45);
    ticks(10);
    check("spin_xpos", xpos, 56);
`ifdef BALL_SPIN_EN
    check("spin_ypos", ypos, 404);
`else
    check("spin_ypos", ypos, 379);
`endif
    tick_until_point(1200, seen);
    check("right_miss_seen", seen, 1);
    check("right_miss_score1", score1, 1);
    check("right_miss_score2", score2, 0);
    for (int i = 2; i <= 9; i++) begin
      ticks(60);
      pulse_start();
      tick_until_point(600, seen);
      check("loop_point_seen", seen, 1);
      check("loop_score1", score1, i);
    end
    ticks(59);
    check("pre_over", game_over, 0);
    do_tick();
    check("game_over", game_over, 1);
    check("over_score1", score1, 9);
    check("over_xpos", xpos, 507);
    pulse_start();
    check("new_game_over", game_over, 0);
    check("new_game_score1", score1, 0);
    check("new_game_score2", score2, 0);
    pulse_start();
    do_tick();
    check("new_game_serve_right", xpos, 508);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
